generation_controller: RTL

Sequencer for the Game-of-Life datapath. It holds the board register and instantiates the combinational `CELL_GRID` next-state array internally. It accepts a board load over a valid/ready handshake and advances generations either one at a time (STEP) or free-running at a programmable interval (START/STOP). It counts generations and halts automatically when the board reaches a still life, which includes extinction.

---
 rtl/conway_pkg.sv | 27 ++
 rtl/cell_grid.sv | 48 ++++
 rtl/generation_controller.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/conway_pkg.sv
// -----------------------------------------------------------------------------
// conway_pkg
// Shared types and sizing for the Game-of-Life datapath.
//   ctrl_state_t        : sequencer states (IDLE / RUN / HALTED)
//   DEFAULT_GRID_WIDTH  : default board columns
//   DEFAULT_GRID_HEIGHT : default board rows
//   grid_cells()        : number of cells for a given width/height
//   GRID_CELLS          : cell count of the default board
// -----------------------------------------------------------------------------
package conway_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } ctrl_state_t;

    localparam int DEFAULT_GRID_WIDTH  = 8;
    localparam int DEFAULT_GRID_HEIGHT = 8;

    function automatic int grid_cells(input int width, input int height);
        return width * height;
    endfunction

    localparam int GRID_CELLS = grid_cells(DEFAULT_GRID_WIDTH, DEFAULT_GRID_HEIGHT);

endpackage

// File: rtl/cell_grid.sv
// -----------------------------------------------------------------------------
// CELL_GRID
// Purely combinational Conway next-state array. Each cell counts its eight
// neighbours; cells outside the board are treated as dead (no wrap-around).
// Ports:
//   INPUT_STATE : current board, bit index = GRID_WIDTH*y + x
//   NEXT_STATE  : board after one generation, same indexing
// -----------------------------------------------------------------------------
module CELL_GRID
    import conway_pkg::*;
#(
    parameter int GRID_WIDTH  = DEFAULT_GRID_WIDTH,
    parameter int GRID_HEIGHT = DEFAULT_GRID_HEIGHT
) (
    input  logic [GRID_WIDTH*GRID_HEIGHT-1:0] INPUT_STATE,
    output logic [GRID_WIDTH*GRID_HEIGHT-1:0] NEXT_STATE
);

    for (genvar y = 0; y < GRID_HEIGHT; y++) begin : g_row
        for (genvar x = 0; x < GRID_WIDTH; x++) begin : g_col
            logic [7:0] nb;
            logic [3:0] live;

            // Neighbour slots are resolved at elaboration time, so edge cells
            // simply tie their off-board neighbours to zero.
            for (genvar k = 0; k < 9; k++) begin : g_nb
                localparam int NX   = x + (k % 3) - 1;
                localparam int NY   = y + (k / 3) - 1;
                localparam int SLOT = (k < 4) ? k : k - 1;
                if (k != 4) begin : g_slot
                    if (NX >= 0 && NX < GRID_WIDTH && NY >= 0 && NY < GRID_HEIGHT) begin : g_in
                        assign nb[SLOT] = INPUT_STATE[NY*GRID_WIDTH + NX];
                    end else begin : g_out
                        assign nb[SLOT] = 1'b0;
                    end
                end
            end

            assign live = {3'd0, nb[0]} + {3'd0, nb[1]} + {3'd0, nb[2]} + {3'd0, nb[3]}
                        + {3'd0, nb[4]} + {3'd0, nb[5]} + {3'd0, nb[6]} + {3'd0, nb[7]};

            // Birth on exactly 3, survival on 2 or 3.
            assign NEXT_STATE[y*GRID_WIDTH + x] =
                (live == 4'd3) || (INPUT_STATE[y*GRID_WIDTH + x] && (live == 4'd2));
        end
    end

endmodule

// File: rtl/generation_controller.sv
// -----------------------------------------------------------------------------
// generation_controller
// Sequencer for the Game-of-Life datapath: holds the board register, loads
// boards over a valid/ready handshake, advances generations on STEP or
// free-running every PERIOD+1 cycles, counts generations (saturating) and
// halts when the board stops changing (still life or extinction).
// Ports:
//   CLK, RST_N  : clock (rising edge), asynchronous active-low reset
//   LOAD_VALID  : LOAD_DATA offered       LOAD_READY : load accepted (not RUN)
//   LOAD_DATA   : new board, bit index = GRID_WIDTH*y + x
//   START/STOP/STEP : commands, priority load > STOP > START > STEP
//   PERIOD      : free-run interval minus one
//   BOARD       : board register          GEN_COUNT  : generations since load
//   GEN_STROBE  : pulse the cycle after a generation was applied
//   RUNNING     : in RUN                  STABLE     : halted on still life
//   EXTINCT     : board is all zero
// -----------------------------------------------------------------------------
module generation_controller
    import conway_pkg::*;
#(
    parameter int GRID_WIDTH   = DEFAULT_GRID_WIDTH,
    parameter int GRID_HEIGHT  = DEFAULT_GRID_HEIGHT,
    parameter int GEN_WIDTH    = 16,
    parameter int PERIOD_WIDTH = 16
) (
    input  logic                              CLK,
    input  logic                              RST_N,
    input  logic                              LOAD_VALID,
    output logic                              LOAD_READY,
    input  logic [GRID_WIDTH*GRID_HEIGHT-1:0] LOAD_DATA,
    input  logic                              START,
    input  logic                              STOP,
    input  logic                              STEP,
    input  logic [PERIOD_WIDTH-1:0]           PERIOD,
    output logic [GRID_WIDTH*GRID_HEIGHT-1:0] BOARD,
    output logic [GEN_WIDTH-1:0]              GEN_COUNT,
    output logic                              GEN_STROBE,
    output logic                              RUNNING,
    output logic                              STABLE,
    output logic                              EXTINCT
);

    localparam int CELLS = grid_cells(GRID_WIDTH, GRID_HEIGHT);

    ctrl_state_t             state_q, state_d;
    logic [CELLS-1:0]        board_q, next_board;
    logic [GEN_WIDTH-1:0]    gen_count_q;
    logic [PERIOD_WIDTH-1:0] timer_q;
    logic                    gen_strobe_q, stable_q;

    logic load_xfer, is_still, period_hit;
    logic do_update, do_advance, timer_clear, timer_inc;

    CELL_GRID #(
        .GRID_WIDTH (GRID_WIDTH),
        .GRID_HEIGHT(GRID_HEIGHT)
    ) u_cell_grid (
        .INPUT_STATE(board_q),
        .NEXT_STATE (next_board)
    );

    assign load_xfer  = LOAD_VALID && (state_q != RUN);
    assign is_still   = (next_board == board_q);
    // Equality only: a PERIOD lowered below the timer waits for the wrap.
    assign period_hit = (timer_q == PERIOD);

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (load_xfer || STOP)      state_d = IDLE;
                else if (START)             state_d = RUN;
                else if (STEP && is_still)  state_d = HALTED;
            end
            RUN: begin
                if (STOP)                         state_d = IDLE;
                else if (period_hit && is_still)  state_d = HALTED;
            end
            HALTED: begin
                if (load_xfer || STOP) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath control decoded from state and commands.
    always_comb begin
        do_update   = 1'b0;
        timer_clear = 1'b0;
        timer_inc   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!load_xfer && !STOP) begin
                    if (START)     timer_clear = 1'b1;
                    else if (STEP) do_update   = 1'b1;
                end
            end
            RUN: begin
                if (!STOP) begin
                    if (period_hit) begin
                        do_update   = 1'b1;
                        timer_clear = 1'b1;
                    end else begin
                        timer_inc = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // An update on a still board only halts; it never counts or strobes.
    assign do_advance = do_update && !is_still;

    // Board, counter, timer and status flags.
    // NOTE: the board is a plain register (not a RAM), so it is reset along
    // with the rest; EXTINCT must read 1 straight out of reset.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            board_q      <= '0;
            gen_count_q  <= '0;
            timer_q      <= '0;
            gen_strobe_q <= 1'b0;
            stable_q     <= 1'b0;
        end else begin
            gen_strobe_q <= do_advance;
            stable_q     <= (state_d == HALTED);

            if (load_xfer) begin
                board_q     <= LOAD_DATA;
                gen_count_q <= '0;
            end else if (do_advance) begin
                board_q <= next_board;
                if (gen_count_q != '1) gen_count_q <= gen_count_q + GEN_WIDTH'(1);
            end

            if (timer_clear)    timer_q <= '0;
            else if (timer_inc) timer_q <= timer_q + PERIOD_WIDTH'(1);
        end
    end

    assign LOAD_READY = (state_q != RUN);
    assign BOARD      = board_q;
    assign GEN_COUNT  = gen_count_q;
    assign GEN_STROBE = gen_strobe_q;
    assign RUNNING    = (state_q == RUN);
    assign STABLE     = stable_q;
    assign EXTINCT    = (board_q == '0);

endmodule
